// File: rtl/use_record_extractor.sv
// use_record_extractor: splits a keep-qualified byte stream into
// var-field / delimiter / fixed-field records, one record per handshake.
module use_record_extractor #(
  parameter int         DATA_BUS_WIDTH_BYTES     = 8,
  parameter logic [7:0] VARIABLEFIELD_DELIMITER  = 8'h2C,
  parameter int         FIXEDFIELD_LENGTH_BYTES  = 17,
  parameter int         MAX_VARIABLEFIELD_LENGTH = 16,
  parameter int         MAX_RECORD_BYTES         =
    MAX_VARIABLEFIELD_LENGTH + 1 + FIXEDFIELD_LENGTH_BYTES
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [8*DATA_BUS_WIDTH_BYTES-1:0]             in_data,
  input  logic [DATA_BUS_WIDTH_BYTES-1:0]               in_keep,
  input  logic                                          in_last,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  output logic [8*MAX_RECORD_BYTES-1:0]                 rec_data,
  output logic [$clog2(MAX_RECORD_BYTES+1)-1:0]         rec_len,
  output logic [$clog2(MAX_VARIABLEFIELD_LENGTH+1)-1:0] rec_var_len,
  output logic                                          rec_valid,
  input  logic                                          rec_ready,
  output logic                                          err_overflow,
  output logic                                          err_truncated,
  output logic [31:0]                                   rec_count,
  output logic [15:0]                                   err_count
);

  localparam int W  = DATA_BUS_WIDTH_BYTES;
  localparam int F  = FIXEDFIELD_LENGTH_BYTES;
  localparam int R  = MAX_RECORD_BYTES;
  localparam int LW = $clog2(R + 1);
  localparam int VW = $clog2(MAX_VARIABLEFIELD_LENGTH + 1);
  localparam int FW = $clog2(F + 1);
  localparam int PW = $clog2(R);

  localparam logic [VW-1:0] VMAX  = VW'(MAX_VARIABLEFIELD_LENGTH);
  localparam logic [FW-1:0] FLAST = FW'(F - 1);
  localparam logic [LW-1:0] FLEN  = LW'(F + 1);

  if (F + 1 <= W) begin : gBeatCheck
    $error("fixed field too short: two records could end in one beat");
  end
  if (R != MAX_VARIABLEFIELD_LENGTH + 1 + F) begin : gSizeCheck
    $error("record buffer size must equal var max + 1 + fixed length");
  end

  typedef enum logic [1:0] {
    StVar,
    StFix,
    StDiscard
  } stateT;

  stateT           st, nSt;
  logic [VW-1:0]   varCnt, nVar;
  logic [FW-1:0]   fixCnt, nFix;
  logic [VW-1:0]   vLat, nVlat;
  logic [8*R-1:0]  recBuf, nBuf;

  logic            accept;
  logic            done;
  logic [8*R-1:0]  doneBuf;
  logic [VW-1:0]   doneVar;
  logic            ovf;
  logic            trunc;
  logic [7:0]      b;
  logic [PW-1:0]   pos;
  logic [PW+2:0]   idx;
  logic [1:0]      errAdd;
  logic [16:0]     errSum;
  logic [15:0]     errNext;

  assign in_ready = ~rec_valid | rec_ready;
  assign accept   = in_valid & in_ready;

  // Lanes step the parser in stream order within a single cycle.
  always_comb begin
    nSt     = st;
    nVar    = varCnt;
    nFix    = fixCnt;
    nVlat   = vLat;
    nBuf    = recBuf;
    done    = 1'b0;
    doneBuf = '0;
    doneVar = '0;
    ovf     = 1'b0;
    trunc   = 1'b0;
    b       = '0;
    pos     = '0;
    idx     = '0;
    for (int i = 0; i < W; i++) begin
      b = in_data[8*i +: 8];
      if (in_keep[i]) begin
        case (nSt)
          StVar: begin
            pos = PW'(nVar);
            idx = {pos, 3'b000};
            if (b == VARIABLEFIELD_DELIMITER) begin
              nBuf[idx +: 8] = b;
              nVlat = nVar;
              nFix  = '0;
              nSt   = StFix;
            end else if (nVar < VMAX) begin
              nBuf[idx +: 8] = b;
              nVar = nVar + 1'b1;
            end else begin
              ovf  = 1'b1;
              nBuf = '0;
              nVar = '0;
              nSt  = StDiscard;
            end
          end
          StFix: begin
            pos = PW'(nVlat) + PW'(nFix) + PW'(1);
            idx = {pos, 3'b000};
            nBuf[idx +: 8] = b;
            if (nFix == FLAST) begin
              done    = 1'b1;
              doneBuf = nBuf;
              doneVar = nVlat;
              nBuf    = '0;
              nVar    = '0;
              nFix    = '0;
              nSt     = StVar;
            end else begin
              nFix = nFix + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
    // A record ending exactly on the last byte leaves StVar with count 0.
    if (in_last) begin
      if (nSt == StDiscard) begin
        nSt = StVar;
      end else if (nSt == StFix || nVar != '0) begin
        trunc = 1'b1;
        nBuf  = '0;
        nVar  = '0;
        nFix  = '0;
        nSt   = StVar;
      end
    end
  end

  always_comb begin
    errAdd  = {1'b0, accept & ovf} + {1'b0, accept & trunc};
    errSum  = {1'b0, err_count} + 17'(errAdd);
    errNext = errSum[16] ? 16'hFFFF : errSum[15:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st            <= StVar;
      varCnt        <= '0;
      fixCnt        <= '0;
      vLat          <= '0;
      recBuf        <= '0;
      rec_data      <= '0;
      rec_len       <= '0;
      rec_var_len   <= '0;
      rec_valid     <= 1'b0;
      err_overflow  <= 1'b0;
      err_truncated <= 1'b0;
      rec_count     <= '0;
      err_count     <= '0;
    end else begin
      if (accept) begin
        st     <= nSt;
        varCnt <= nVar;
        fixCnt <= nFix;
        vLat   <= nVlat;
        recBuf <= nBuf;
      end
      if (accept && done) begin
        rec_data    <= doneBuf;
        rec_len     <= LW'(doneVar) + FLEN;
        rec_var_len <= doneVar;
        rec_valid   <= 1'b1;
      end else if (rec_ready) begin
        rec_valid <= 1'b0;
      end
      if (rec_valid && rec_ready) begin
        rec_count <= rec_count + 32'd1;
      end
      err_overflow  <= accept & ovf;
      err_truncated <= accept & trunc;
      err_count     <= errNext;
    end
  end

endmodule
